// File: rtl/key_pkg.sv
// Shared types and default timing for the per-key event decoder.
// Default cycle counts assume a 50 MHz system clock.
package key_pkg;

  localparam int LONG_CYC_DEF = 50_000_000;
  localparam int GAP_CYC_DEF  = 15_000_000;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HOLD
  } key_evt_state_t;

endpackage

// File: rtl/key_event_decoder.sv
// Classifies one debounced key into click, double click and long press.
// One FSM plus a shared saturating cycle counter; all outputs registered.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int LONG_CYC = LONG_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  input  logic key_state,
  output logic click,
  output logic dbl_click,
  output logic long_press,
  output logic busy
);

  localparam int MAX_CYC = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC);

  localparam logic [CW-1:0] LONG_END = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYC - 1);

  key_evt_state_t r_state;
  key_evt_state_t w_next;
  logic [CW-1:0]  r_cnt;

  logic r_click;
  logic r_dbl;
  logic r_long;
  logic r_busy;

  logic w_press;
  logic w_rel;
  logic w_long_hit;
  logic w_gap_hit;
  logic w_click;
  logic w_dbl;
  logic w_long;

  assign w_press    = key_flag & ~key_state;
  assign w_rel      = key_flag & key_state;
  assign w_long_hit = (r_cnt == LONG_END);
  assign w_gap_hit  = (r_cnt == GAP_END);

  // State, counter and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_click <= 1'b0;
      r_dbl   <= 1'b0;
      r_long  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_click <= w_click;
      r_dbl   <= w_dbl;
      r_long  <= w_long;
      r_busy  <= (w_next != IDLE);
    end
  end

  // Release beats the long threshold; press beats the gap timeout
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_press) w_next = PRESS1;
      end
      PRESS1: begin
        if (w_rel)           w_next = WAIT2;
        else if (w_long_hit) w_next = LONG_HOLD;
      end
      WAIT2: begin
        if (w_press)        w_next = PRESS2;
        else if (w_gap_hit) w_next = IDLE;
      end
      PRESS2: begin
        if (w_rel) w_next = IDLE;
      end
      LONG_HOLD: begin
        if (w_rel) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_click = 1'b0;
    w_dbl   = 1'b0;
    w_long  = 1'b0;
    unique case (r_state)
      PRESS1:  w_long  = w_long_hit & ~w_rel;
      WAIT2:   w_click = w_gap_hit & ~w_press;
      PRESS2:  w_dbl   = w_rel;
      default: ;
    endcase
  end

  assign click      = r_click;
  assign dbl_click  = r_dbl;
  assign long_press = r_long;
  assign busy       = r_busy;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder with an event-list reference.
// Directed boundary scenarios followed by randomized key traffic.
module tb_key_event_decoder;

  localparam int LONG = 20;
  localparam int GAP  = 10;
  localparam int BIG  = 1 << 28;
  localparam int INF  = 32'h7fff_ffff;

  localparam logic [2:0] K_CLICK = 3'b001;
  localparam logic [2:0] K_DBL   = 3'b010;
  localparam logic [2:0] K_LONG  = 3'b100;

  typedef struct {
    int         cyc;
    logic [2:0] k;
  } exp_t;

  typedef struct {
    int   cyc;
    logic v;
  } bexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_flag = 1'b0;
  logic key_state = 1'b1;
  logic click;
  logic dbl_click;
  logic long_press;
  logic busy;

  key_event_decoder #(
    .LONG_CYC(LONG),
    .GAP_CYC (GAP)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .key_flag  (key_flag),
    .key_state (key_state),
    .click     (click),
    .dbl_click (dbl_click),
    .long_press(long_press),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   base  = 0;
  bit   mon_en = 1'b0;
  int   ev_t[$];
  bit   ev_p[$];
  int   rst_at;
  int   scen_len;
  exp_t  q_out[$];
  bexp_t q_busy[$];

  // ---------------- reference model ----------------
  function automatic int next_ev(int after, bit want, int to_t);
    foreach (ev_t[i]) begin
      if (ev_t[i] > after && ev_t[i] < to_t && ev_p[i] == want)
        return ev_t[i];
    end
    return -1;
  endfunction

  function automatic void add_out(int c, logic [2:0] k, int cutoff);
    exp_t e;
    if (c > cutoff) return;
    e.cyc = c;
    e.k   = k;
    q_out.push_back(e);
  endfunction

  function automatic void add_busy(int c, logic v, int cutoff);
    bexp_t b;
    if (c > cutoff) return;
    b.cyc = c;
    b.v   = v;
    q_busy.push_back(b);
  endfunction

  // One press sequence at a time, derived from event times alone
  function automatic void seg_model(int from_t, int to_t, int cutoff);
    int t, p, r, p2, r2, e, prev_e;
    t      = from_t - 1;
    prev_e = from_t;
    forever begin
      p = next_ev(t, 1'b1, to_t);
      if (p < 0) break;
      if (p > prev_e) add_busy(p, 1'b0, cutoff);
      add_busy(p + 1, 1'b1, cutoff);
      r = next_ev(p, 1'b0, to_t);
      if (r < 0 || r > p + LONG) begin
        add_out(p + LONG + 1, K_LONG, cutoff);
        e = (r < 0) ? INF : r + 1;
        t = r;
      end else begin
        p2 = next_ev(r, 1'b1, to_t);
        if (p2 >= 0 && p2 <= r + GAP) begin
          r2 = next_ev(p2, 1'b0, to_t);
          if (r2 < 0) begin
            e = INF;
          end else begin
            add_out(r2 + 1, K_DBL, cutoff);
            e = r2 + 1;
          end
          t = r2;
        end else begin
          add_out(r + GAP + 1, K_CLICK, cutoff);
          e = r + GAP + 1;
          t = r + GAP;
        end
      end
      if (e == INF || e > cutoff) begin
        if (cutoff < BIG) add_busy(cutoff + 1, 1'b0, INF);
        break;
      end
      add_busy(e - 1, 1'b1, cutoff);
      add_busy(e, 1'b0, cutoff);
      prev_e = e;
    end
  endfunction

  // ---------------- monitor ----------------
  logic [2:0] act;
  int         rel;

  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - base;
      act = {long_press, dbl_click, click};
      while (q_out.size() > 0 && q_out[0].cyc < rel) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_pulse: cycle %0d got none, required kind %b",
                 q_out[0].cyc, q_out[0].k);
        void'(q_out.pop_front());
      end
      if (act != 3'b000) begin
        n_cmp++;
        if (q_out.size() > 0 && q_out[0].cyc == rel) begin
          if (act != q_out[0].k) begin
            n_bad++;
            $display("FAIL pulse_kind: cycle %0d got %b, required %b",
                     rel, act, q_out[0].k);
          end
          void'(q_out.pop_front());
        end else begin
          n_bad++;
          $display("FAIL unexpected_pulse: cycle %0d got %b, required 000",
                   rel, act);
        end
      end
      while (q_busy.size() > 0 && q_busy[0].cyc <= rel) begin
        if (q_busy[0].cyc == rel) begin
          n_cmp++;
          if (busy !== q_busy[0].v) begin
            n_bad++;
            $display("FAIL busy: cycle %0d got %b, required %b",
                     rel, busy, q_busy[0].v);
          end
        end
        void'(q_busy.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic clr();
    ev_t.delete();
    ev_p.delete();
    rst_at = -1;
  endtask

  task automatic ev(int t, bit p);
    ev_t.push_back(t);
    ev_p.push_back(p);
  endtask

  task automatic run_scen();
    int idx;
    q_out.delete();
    q_busy.delete();
    if (rst_at < 0) begin
      seg_model(0, BIG, BIG);
    end else begin
      seg_model(0, rst_at, rst_at);
      seg_model(rst_at + 1, BIG, BIG);
    end
    scen_len = ev_t[ev_t.size() - 1] + LONG + GAP + 6;
    mon_en   = 1'b0;
    key_flag = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
    n_cmp++;
    if ({click, dbl_click, long_press, busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_state: got %b, required 0000",
               {click, dbl_click, long_press, busy});
    end
    mon_en = 1'b1;
    idx = 0;
    for (int c = 0; c < scen_len; c++) begin
      key_flag = 1'b0;
      rst      = (c == rst_at);
      if (idx < ev_t.size() && ev_t[idx] == c) begin
        key_flag  = 1'b1;
        key_state = ~ev_p[idx];
        idx++;
      end
      @(posedge clk);
      #1;
    end
    key_flag = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    while (q_out.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missed_pulse_end: cycle %0d got none, required %b",
               q_out[0].cyc, q_out[0].k);
      void'(q_out.pop_front());
    end
    while (q_busy.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_unchecked: cycle %0d got none, required %b",
               q_busy[0].cyc, q_busy[0].v);
      void'(q_busy.pop_front());
    end
  endtask

  task automatic gen_random();
    int t, n, d;
    bit lvl, p;
    clr();
    t   = 1;
    lvl = 1'b0;
    n   = $urandom_range(3, 10);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 5))
        0:       d = $urandom_range(1, 3);
        1:       d = $urandom_range(5, 9);
        2:       d = $urandom_range(GAP - 1, GAP + 1);
        3:       d = $urandom_range(LONG - 1, LONG + 1);
        4:       d = $urandom_range(25, 35);
        default: d = $urandom_range(2, 6);
      endcase
      t += d;
      if ($urandom_range(0, 9) < 8) p = ~lvl;
      else p = 1'($urandom_range(0, 1));
      lvl = p;
      ev(t, p);
    end
    if (lvl) ev(t + $urandom_range(1, 5), 1'b0);
    if ($urandom_range(0, 4) == 0)
      rst_at = $urandom_range(3, ev_t[ev_t.size() - 1]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // single click
    clr(); ev(5, 1); ev(10, 0); run_scen();
    // double click
    clr(); ev(5, 1); ev(10, 0); ev(15, 1); ev(20, 0); run_scen();
    // long press
    clr(); ev(5, 1); ev(40, 0); run_scen();
    // release exactly at long threshold
    clr(); ev(5, 1); ev(25, 0); run_scen();
    // press on last gap cycle
    clr(); ev(5, 1); ev(10, 0); ev(20, 1); ev(25, 0); run_scen();
    // press one cycle after gap, coincides with click
    clr(); ev(5, 1); ev(10, 0); ev(21, 1); ev(30, 0); run_scen();
    // reset mid-press
    clr(); ev(5, 1); ev(15, 0); rst_at = 12; run_scen();
    // redundant events and long hold in PRESS2
    clr(); ev(3, 0); ev(5, 1); ev(7, 1); ev(10, 0); ev(12, 0);
    ev(14, 1); ev(50, 0); run_scen();
    for (int i = 0; i < 40; i++) begin
      gen_random();
      run_scen();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Consumer side of the debounced key interface. Takes one key's confirmed edge pulse (`key_flag`) and debounced level (`key_state`) from a key filter instance and classifies presses into single click, double click and long press. It emits one-cycle event pulses to the application logic. One instance is used per key; the top level instantiates one per debounced key channel.

## Interface
- `LONG_CYC`, 50_000_000: hold duration in clock cycles that qualifies as a long press (1 s at 50 MHz); must be ≥ 2.
- `GAP_CYC`, 15_000_000: maximum release-to-press gap in cycles for a double click (300 ms at 50 MHz); must be ≥ 2.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `key_flag` in 1: one-cycle pulse when a debounced press or release is confirmed.
- `key_state` in 1: debounced key level; 0 = pressed, 1 = released. Valid whenever `key_flag` = 1.
- `click` out 1: one-cycle pulse, single short press detected.
- `dbl_click` out 1: one-cycle pulse, double click detected.
- `long_press` out 1: one-cycle pulse, long press detected.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Press event: `key_flag & ~key_state`. Release event: `key_flag & key_state`.
- One counter, width `$clog2(max(LONG_CYC, GAP_CYC))`. It clears on every state change and increments every cycle otherwise. It saturates and never wraps.
- FSM states are IDLE, PRESS1, WAIT2, PRESS2 and LONG_HOLD.
  - IDLE: a press event moves to PRESS1. Release events are ignored.
  - PRESS1:
    - A release event with `cnt < LONG_CYC-1` moves to WAIT2.
    - If `cnt == LONG_CYC-1` and there is no release event, `long_press` fires and the FSM moves to LONG_HOLD.
    - A release event in the same cycle as the long-press threshold wins, so the press is treated as short.
  - LONG_HOLD: a release event moves to IDLE with no output. Press events are ignored.
  - WAIT2:
    - A press event moves to PRESS2.
    - If `cnt == GAP_CYC-1` and there is no press event, `click` fires and the FSM moves to IDLE.
    - A press event in the same cycle as the timeout wins.
  - PRESS2: a release event fires `dbl_click` and moves to IDLE, regardless of hold length. There is no long press from PRESS2.
- Events that do not match the current state are ignored: a press while pressed, or a release while released.
- At most one output pulse is high in any cycle.

## Timing
- Reset values: state IDLE, counter 0, `click` = `dbl_click` = `long_press` = `busy` = 0.
- Reset applied mid-sequence returns the FSM to IDLE on the next edge. The pending sequence is discarded without an output, and a following release is ignored.
- All outputs are registered.
- `busy` rises 1 cycle after the press event.
- Press event at cycle t with no release: `long_press` is high at cycle t+LONG_CYC+1.
- Release event at cycle r in PRESS1 with no further press: `click` is high at cycle r+GAP_CYC+1.
- Release event in PRESS2 at cycle r: `dbl_click` is high at r+1.
- A press event arriving in the same cycle as a `click` pulse, or later, starts a new sequence from IDLE.

## Structure
- Shared package `key_pkg`:
  - state enum `key_evt_state_t` with the five states above;
  - localparams for the default `LONG_CYC`/`GAP_CYC` at 50 MHz.
- No sub-module. The block is a single FSM plus one counter. Per-key replication is done by the parent.

## Test plan
Bench parameters: LONG_CYC=20, GAP_CYC=10, reset released before cycle 0.
- Single click: press at 5, release at 10 → `click` high only at 21; `busy` low from 21.
- Double click: press 5, release 10, press 15, release 20 → `dbl_click` at 21, no `click`.
- Long press: press 5, release 40 → `long_press` at 26, nothing at release.
- Long-press threshold boundary: press 5, release at 25 (cnt = 19) → no `long_press`, `click` at 36.
- Gap boundary:
  - press 5, release 10, press 20 → PRESS2, and a release at 25 gives `dbl_click` at 26;
  - alternatively, press at 21 → `click` at 21 and a new PRESS1 sequence starts.
- Reset mid-operation: press 5, `rst` high at 12 for 1 cycle, release 15 → no output pulses, `busy` low from 13.
